bsg_fpu_i2f_iter: RTL and testbench

BSG_FPU_I2F_ITER -- requirements
Module: bsg_fpu_i2f_iter

---
 rtl/bsg_fpu_i2f_iter.sv | 122 ++++++++++++
 tb/tb_bsg_fpu_i2f_iter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_i2f_iter.sv
// bsg_fpu_i2f_iter
// Iterative 32-bit integer to IEEE-754 single-precision converter. The
// magnitude is normalised one bit per cycle, then rounded to nearest-even.
// Handshake is valid/ready on the input side and valid/yumi on the output.
//
// Ports
//   clk_i      : clock, all state changes on the rising edge
//   reset_i    : asynchronous active-high reset
//   v_i        : operand valid
//   ready_o    : block can accept an operand (IDLE only)
//   a_i        : 32-bit integer operand, sampled on accept
//   signed_i   : 1 = a_i is two's complement, 0 = unsigned; sampled on accept
//   v_o        : result valid (DONE only)
//   z_o        : float result {sign, exp[7:0], man[22:0]}
//   inexact_o  : result was rounded (guard | sticky nonzero)
//   yumi_i     : consumer takes the result; only meaningful while v_o = 1

module bsg_fpu_i2f_iter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        v_i,
  output logic        ready_o,
  input  logic [31:0] a_i,
  input  logic        signed_i,
  output logic        v_o,
  output logic [31:0] z_o,
  output logic        inexact_o,
  input  logic        yumi_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Exponent of a value whose leading one sits at bit 31: 127 + 31.
  localparam logic [7:0] EXP_INIT = 8'd158;

  logic [1:0]  state_r;
  logic        sign_r;
  logic [31:0] mag_r;
  logic [7:0]  exp_r;
  logic [31:0] z_r;
  logic        inexact_r;

  // Operand conditioning. Negating 0x80000000 wraps back to 0x80000000,
  // which is exactly the magnitude we want for the most negative input.
  logic        a_sign;
  logic [31:0] a_mag;
  assign a_sign = signed_i & a_i[31];
  assign a_mag  = a_sign ? (~a_i + 32'd1) : a_i;

  // Rounding datapath, valid once mag_r[31] is set (hidden bit dropped).
  logic        lsb;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] man_sum;
  logic [7:0]  exp_rnd;

  assign lsb      = mag_r[8];
  assign guard    = mag_r[7];
  assign sticky   = |mag_r[6:0];
  assign round_up = guard & (sticky | lsb);
  // A carry out of the 23-bit mantissa leaves man_sum[22:0] at zero, so only
  // the exponent needs adjusting. exp_r is at most 158 here, so no overflow.
  assign man_sum  = {1'b0, mag_r[30:8]} + {23'd0, round_up};
  assign exp_rnd  = exp_r + {7'd0, man_sum[23]};

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      sign_r    <= 1'b0;
      mag_r     <= 32'd0;
      exp_r     <= 8'd0;
      z_r       <= 32'd0;
      inexact_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (v_i) begin
            sign_r <= a_sign;
            mag_r  <= a_mag;
            exp_r  <= EXP_INIT;
            if (a_mag == 32'd0) begin
              // Zero bypasses normalisation; result is +0 regardless of sign.
              z_r       <= 32'd0;
              inexact_r <= 1'b0;
              state_r   <= DONE;
            end else begin
              state_r <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_r[31]) begin
            state_r <= ROUND;
          end else begin
            mag_r <= mag_r << 1;
            exp_r <= exp_r - 8'd1;
          end
        end
        ROUND: begin
          z_r       <= {sign_r, exp_rnd, man_sum[22:0]};
          inexact_r <= guard | sticky;
          state_r   <= DONE;
        end
        DONE: begin
          if (yumi_i) state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready_o   = (state_r == IDLE);
  assign v_o       = (state_r == DONE);
  assign z_o       = z_r;
  assign inexact_o = inexact_r;

endmodule

// File: tb/tb_bsg_fpu_i2f_iter.sv
// Testbench for bsg_fpu_i2f_iter. Directed operands are driven one at a time;
// the expected result and latency are pushed to a scoreboard queue when the
// operand is driven and popped when the DUT raises v_o.

module tb_bsg_fpu_i2f_iter;

  logic        clk_i;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic        signed_i;
  logic        v_o;
  logic [31:0] z_o;
  logic        inexact_o;
  logic        yumi_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] z;
    logic        inexact;
    int          latency;
  } exp_t;

  exp_t sb[$];

  bsg_fpu_i2f_iter dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .signed_i  (signed_i),
    .v_o       (v_o),
    .z_o       (z_o),
    .inexact_o (inexact_o),
    .yumi_i    (yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operand, wait (bounded) for v_o, compare against the
  // scoreboard head, then retire the result with a one-cycle yumi.
  task automatic convert(input string tag, input logic [31:0] a, input logic sgn,
                         input logic [31:0] z_exp, input logic inx_exp, input int lat_exp);
    exp_t e;
    int   cycles;
    sb.push_back('{z: z_exp, inexact: inx_exp, latency: lat_exp});
    @(negedge clk_i);
    check({tag, ".ready"}, {31'd0, ready_o}, 32'd1);
    v_i      = 1'b1;
    a_i      = a;
    signed_i = sgn;
    @(posedge clk_i);
    #1 v_i = 1'b0;
    a_i = 32'hDEAD_BEEF;
    cycles = 0;
    do begin
      @(posedge clk_i);
      cycles++;
      @(negedge clk_i);
    end while (!v_o && cycles < 50);
    e = sb.pop_front();
    check({tag, ".lat"}, cycles, e.latency);
    check({tag, ".z"}, z_o, e.z);
    check({tag, ".inexact"}, {31'd0, inexact_o}, {31'd0, e.inexact});
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1 yumi_i = 1'b0;
    check({tag, ".retire_v"}, {31'd0, v_o}, 32'd0);
  endtask

  initial begin
    reset_i  = 1'b1;
    v_i      = 1'b0;
    a_i      = 32'd0;
    signed_i = 1'b0;
    yumi_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset.ready", {31'd0, ready_o}, 32'd1);
    check("reset.v", {31'd0, v_o}, 32'd0);
    check("reset.z", z_o, 32'd0);
    check("reset.inexact", {31'd0, inexact_o}, 32'd0);
    reset_i = 1'b0;

    convert("s_one",      32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0, 33);
    convert("s_min",      32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 2);
    convert("s_neg1",     32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 33);
    convert("u_max",      32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 2);
    convert("u_tie_even", 32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 9);
    convert("u_tie_up",   32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 9);
    convert("s_neg5",     32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 31);

    // Zero operand, then hold the result for 10 cycles while v_i pulses.
    begin
      exp_t e;
      sb.push_back('{z: 32'h0000_0000, inexact: 1'b0, latency: 1});
      @(negedge clk_i);
      v_i = 1'b1; a_i = 32'd0; signed_i = 1'b1;
      @(posedge clk_i);
      #1 v_i = 1'b0;
      @(negedge clk_i);
      e = sb.pop_front();
      check("zero.v_after_1", {31'd0, v_o}, 32'd1);
      check("zero.z", z_o, e.z);
      check("zero.inexact", {31'd0, inexact_o}, {31'd0, e.inexact});
      for (int i = 0; i < 10; i++) begin
        v_i = i[0];
        a_i = 32'h1234_5678;
        signed_i = 1'b0;
        @(negedge clk_i);
        check("hold.v", {31'd0, v_o}, 32'd1);
        check("hold.z", z_o, e.z);
        check("hold.ready", {31'd0, ready_o}, 32'd0);
      end
      v_i = 1'b0;
      yumi_i = 1'b1;
      @(posedge clk_i);
      #1 yumi_i = 1'b0;
      check("zero.retire_ready", {31'd0, ready_o}, 32'd1);
    end

    // A nonzero result so the reset clearing z_o is observable.
    convert("u_three", 32'h0000_0003, 1'b0, 32'h4040_0000, 1'b0, 32);
    check("retain.z", z_o, 32'h4040_0000);

    // Reset during NORM aborts the conversion.
    @(negedge clk_i);
    v_i = 1'b1; a_i = 32'h0000_0001; signed_i = 1'b1;
    @(posedge clk_i);
    #1 v_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("norm.busy", {31'd0, ready_o}, 32'd0);
    reset_i = 1'b1;
    #1;
    check("abort.v", {31'd0, v_o}, 32'd0);
    check("abort.ready", {31'd0, ready_o}, 32'd1);
    check("abort.z", z_o, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (v_o) break;
    end
    check("abort.no_result", {31'd0, v_o}, 32'd0);

    convert("post_reset_two", 32'h0000_0002, 1'b0, 32'h4000_0000, 1'b0, 32);

    check("sb.empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
